// File: rtl/mar_if.sv
// Bus between the SAP-1 controller/front panel and the memory address register.
// The master drives load, mode, switches and W-bus data; the slave returns the RAM address.
interface mar_if #(
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic                  Lm;
  logic                  SELECT;
  logic [ADDR_WIDTH-1:0] A;
  logic [ADDR_WIDTH-1:0] D;
  logic [ADDR_WIDTH-1:0] Out;

  modport master (
    output Lm,
    output SELECT,
    output A,
    output D,
    input  Out
  );

  modport slave (
    input  Lm,
    input  SELECT,
    input  A,
    input  D,
    output Out
  );

endinterface

// File: rtl/mar.sv
// SAP-1 memory address register.
// Captures the W-bus address on load; in programming mode the front-panel switches bypass it.
module mar #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic   CLK,
  input logic   CLR,
  mar_if.slave  bus
);

  localparam int unsigned AW = ADDR_WIDTH;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  // Clear beats load; otherwise hold.
  always_comb begin
    addr_d = addr_q;
    if (CLR) begin
      addr_d = '0;
    end else if (bus.Lm) begin
      addr_d = bus.D;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
  end

  // Mode mux stays combinational so the panel sees switch changes without a clock.
  assign bus.Out = bus.SELECT ? addr_q : bus.A;

endmodule

// File: tb/tb_mar.sv
// Directed bench for the SAP-1 memory address register.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_mar;

  localparam int unsigned AW = 4;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  mar_if #(.ADDR_WIDTH(AW)) bus ();

  mar #(.ADDR_WIDTH(AW)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] exp);
    logic [AW-1:0] obs;
    obs   = bus.Out;
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    clr        = 1'b1;
    bus.Lm     = 1'b0;
    bus.SELECT = 1'b1;
    bus.A      = 4'b0000;
    bus.D      = 4'b0000;

    // Reset
    tick();
    chk("reset_run", 4'b0000);
    bus.A      = 4'b1110;
    bus.SELECT = 1'b0;
    #1;
    chk("reset_prog", 4'b1110);
    clr = 1'b0;

    // Programming passthrough, no edge needed
    bus.A = 4'b1010;
    #1;
    chk("pass_1010", 4'b1010);
    bus.A = 4'b0101;
    #1;
    chk("pass_0101", 4'b0101);

    // Load then run
    bus.D  = 4'b1100;
    bus.Lm = 1'b1;
    tick();
    bus.Lm = 1'b0;
    chk("load_prog_shows_A", 4'b0101);
    bus.SELECT = 1'b1;
    #1;
    chk("load_run", 4'b1100);

    // Hold without load
    bus.D = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", 4'b1100);
    end

    // Reset priority over load
    clr    = 1'b1;
    bus.Lm = 1'b1;
    bus.D  = 4'b1111;
    tick();
    clr    = 1'b0;
    bus.Lm = 1'b0;
    chk("clr_over_lm", 4'b0000);

    // Load in programming mode
    bus.SELECT = 1'b0;
    bus.A      = 4'b0001;
    bus.D      = 4'b0110;
    bus.Lm     = 1'b1;
    tick();
    bus.Lm = 1'b0;
    chk("prog_load_hidden", 4'b0001);
    tick();
    chk("prog_load_hidden2", 4'b0001);
    bus.SELECT = 1'b1;
    #1;
    chk("prog_load_visible", 4'b0110);

    // Back-to-back loads
    bus.D  = 4'b0010;
    bus.Lm = 1'b1;
    tick();
    chk("b2b_first", 4'b0010);
    bus.D = 4'b0111;
    tick();
    chk("b2b_second", 4'b0111);
    bus.Lm = 1'b0;
    bus.D  = 4'b0000;
    tick();
    chk("b2b_hold", 4'b0111);

    // Full-width capture
    bus.D  = 4'b1111;
    bus.Lm = 1'b1;
    tick();
    bus.Lm = 1'b0;
    chk("full_width", 4'b1111);

    // Mid-operation reset while in programming mode
    bus.SELECT = 1'b0;
    bus.A      = 4'b1001;
    clr        = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_prog_shows_A", 4'b1001);
    bus.SELECT = 1'b1;
    #1;
    chk("clr_prog_then_run", 4'b0000);

    // Switch changes ignored in run mode
    bus.A = 4'b0110;
    #1;
    chk("run_ignores_A", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
